aexm_ifq: RTL

Instruction prefetch queue and decode latch for the AEXM core. It sits between the instruction cache return path and the control/decode stage, and buffers fetched words in a small FIFO. It presents the execute-side instruction word (xIREG) and the registered, field-split decode-side word (rOPC/rRD/rRA/rRB/rALT/rIMM). It also merges IMM-prefix (opcode 6'o54) upper halves into a 32-bit operand.

---
 rtl/aexm_ifq.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/aexm_ifq.sv
// AEXM instruction prefetch queue: buffers icache words in a small FIFO, presents
// the execute-side word (xIREG) and a registered, field-split decode word with IMM-prefix merge.
module aexm_ifq #(
    parameter int          DEPTH = 4,
    parameter int          AW    = 2,
    parameter logic [31:0] NOP   = 32'h8000_0000
) (
    input  logic          gclk,
    input  logic          grst,
    input  logic          d_en,
    input  logic          fSTALL,
    input  logic          flush,
    input  logic [31:0]   fet_dat,
    input  logic          fet_vld,
    output logic          fet_rdy,
    output logic [31:0]   xIREG,
    output logic          xVALID,
    output logic [5:0]    rOPC,
    output logic [4:0]    rRD,
    output logic [4:0]    rRA,
    output logic [4:0]    rRB,
    output logic [10:0]   rALT,
    output logic [15:0]   rIMM,
    output logic [31:0]   rSIMM,
    output logic [AW:0]   q_cnt
);

    localparam logic [5:0]    OPC_IMM = 6'o54;
    localparam logic [AW:0]   CNT_MAX = (AW+1)'(DEPTH);
    localparam logic [AW:0]   CNT_ONE = (AW+1)'(1);
    localparam logic [AW-1:0] PTR_ONE = AW'(1);

    logic [31:0]   r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_cnt;

    logic [31:0]   r_xireg;
    logic          r_xvalid;
    logic [31:0]   r_dec;
    logic [31:0]   r_simm;
    logic [15:0]   r_imm_hi;
    logic          r_imm_pending;

    logic          w_push;
    logic          w_adv;
    logic          w_empty;
    logic          w_bypass;
    logic          w_wr;
    logic          w_pop;
    logic [5:0]    w_xopc;
    logic [31:0]   w_xsext;

    // Ready depends only on reset and occupancy so it never loops back through the pipeline.
    assign fet_rdy  = grst & (r_cnt < CNT_MAX);
    assign w_push   = fet_vld & fet_rdy;
    assign w_adv    = d_en & ~fSTALL;
    assign w_empty  = (r_cnt == '0);
    assign w_bypass = w_empty & w_adv & w_push & ~flush;
    assign w_wr     = w_push & ~w_bypass & ~flush;
    assign w_pop    = w_adv & ~w_empty & ~flush;
    assign w_xopc   = r_xireg[31:26];
    assign w_xsext  = {{16{r_xireg[15]}}, r_xireg[15:0]};

    always_ff @(posedge gclk) begin
        if (w_wr) begin
            r_mem[r_wr_ptr] <= fet_dat;
        end
    end

    // Queue pointers and occupancy; flush wins over both push and pop.
    always_ff @(posedge gclk or negedge grst) begin
        if (!grst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_cnt    <= '0;
        end else if (flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_cnt    <= '0;
        end else begin
            if (w_wr) begin
                r_wr_ptr <= r_wr_ptr + PTR_ONE;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_ONE;
            end
            case ({w_wr, w_pop})
                2'b10:   r_cnt <= r_cnt + CNT_ONE;
                2'b01:   r_cnt <= r_cnt - CNT_ONE;
                default: r_cnt <= r_cnt;
            endcase
        end
    end

    // Execute-side latch: head of queue, bypassed fetch word, or a bubble.
    always_ff @(posedge gclk or negedge grst) begin
        if (!grst) begin
            r_xireg  <= NOP;
            r_xvalid <= 1'b0;
        end else if (flush) begin
            r_xireg  <= NOP;
            r_xvalid <= 1'b0;
        end else if (w_adv) begin
            if (!w_empty) begin
                r_xireg  <= r_mem[r_rd_ptr];
                r_xvalid <= 1'b1;
            end else if (w_push) begin
                r_xireg  <= fet_dat;
                r_xvalid <= 1'b1;
            end else begin
                r_xireg  <= NOP;
                r_xvalid <= 1'b0;
            end
        end
    end

    // Decode stage advances even during flush so the delay-slot word is not lost.
    always_ff @(posedge gclk or negedge grst) begin
        if (!grst) begin
            r_dec         <= '0;
            r_simm        <= '0;
            r_imm_hi      <= '0;
            r_imm_pending <= 1'b0;
        end else if (w_adv) begin
            r_dec <= r_xireg;
            if (r_xvalid && (w_xopc == OPC_IMM)) begin
                r_imm_hi      <= r_xireg[15:0];
                r_imm_pending <= 1'b1;
                r_simm        <= w_xsext;
            end else if (r_xvalid && r_imm_pending) begin
                r_imm_pending <= 1'b0;
                r_simm        <= {r_imm_hi, r_xireg[15:0]};
            end else begin
                // Bubbles leave a pending prefix in place for the next real word.
                r_simm <= w_xsext;
            end
        end
    end

    assign xIREG  = r_xireg;
    assign xVALID = r_xvalid;
    assign rOPC   = r_dec[31:26];
    assign rRD    = r_dec[25:21];
    assign rRA    = r_dec[20:16];
    assign rRB    = r_dec[15:11];
    assign rALT   = r_dec[10:0];
    assign rIMM   = r_dec[15:0];
    assign rSIMM  = r_simm;
    assign q_cnt  = r_cnt;

endmodule
